// File: rtl/pipe_pkg.sv
// Purpose: shared types and constants for the pipeline hazard controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package pipe_pkg;

  // Controller FSM: RUN is normal flow, MWAIT holds the pipe on a slow memory access
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    MWAIT = 1'b1
  } state_t;

  // Register-number width of the register file
  localparam int REG_W = 5;

  // Operand forwarding selects seen by the ID-stage operand muxes
  localparam logic [1:0] FWD_RF   = 2'd0;  // register file read data
  localparam logic [1:0] FWD_EXE  = 2'd1;  // EX-stage ALU result
  localparam logic [1:0] FWD_MALU = 2'd2;  // MEM-stage ALU result
  localparam logic [1:0] FWD_MMEM = 2'd3;  // MEM-stage load data

  // True when a producer writes a nonzero destination that matches a source.
  // Register 0 is hardwired to zero, so it never counts as a dependency.
  function automatic logic reg_hit(input logic             wr,
                                   input logic [REG_W-1:0] dst,
                                   input logic [REG_W-1:0] src);
    return wr & (dst != '0) & (dst == src);
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Purpose: forwarding select for one ID-stage source operand (EX result beats MEM result).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the select is valid whenever the inputs are.
module pipe_fwd_unit
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] i_src,
  input  logic             i_ewreg,
  input  logic             i_em2reg,
  input  logic [REG_W-1:0] i_ern,
  input  logic             i_mwreg,
  input  logic             i_mm2reg,
  input  logic [REG_W-1:0] i_mrn,
  output logic [1:0]       o_sel
);

  // Youngest producer wins; a load still in EX cannot be forwarded (load-use stall covers it)
  always_comb begin
    o_sel = FWD_RF;
    if (reg_hit(i_ewreg & ~i_em2reg, i_ern, i_src)) begin
      o_sel = FWD_EXE;
    end else if (reg_hit(i_mwreg & ~i_mm2reg, i_mrn, i_src)) begin
      o_sel = FWD_MALU;
    end else if (reg_hit(i_mwreg & i_mm2reg, i_mrn, i_src)) begin
      o_sel = FWD_MMEM;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: stall/flush/forward control for the 5-stage pipe plus data-memory wait handling.
// Latency: enables, bubbles and forward selects are combinational; state/counters update each clock.
// Backpressure: dmem_ready low freezes the whole pipe until ready or the wait times out.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32,
  parameter int DELAY_SLOT  = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_rt,
  input  logic             i_users,
  input  logic             i_usert,
  input  logic             i_branch_taken,
  input  logic             i_ewreg,
  input  logic             i_em2reg,
  input  logic [REG_W-1:0] i_ern,
  input  logic             i_mwreg,
  input  logic             i_mm2reg,
  input  logic [REG_W-1:0] i_mrn,
  input  logic             i_mmem,
  input  logic             i_dmem_ready,
  output logic             o_dmem_req,
  output logic             o_wpcir,
  output logic             o_fd_flush,
  output logic             o_de_en,
  output logic             o_de_bubble,
  output logic             o_em_en,
  output logic             o_mw_bubble,
  output logic [1:0]       o_fwda,
  output logic [1:0]       o_fwdb,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_stall_cycles
);

  // Wide enough to hold MEM_TIMEOUT itself, so the final increment never wraps
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_in_wait;
  logic w_timeout;
  logic w_wait_exit;
  logic w_freeze;
  logic w_load_use;
  logic w_wpcir;

  // Memory-wait bookkeeping: last permitted wait cycle and the cycle that leaves MWAIT
  always_comb begin
    w_in_wait   = (r_state == MWAIT);
    w_timeout   = w_in_wait & (r_wait_cnt == WAIT_LAST);
    w_wait_exit = w_in_wait & (i_dmem_ready | w_timeout);
  end

  // Freeze on a missed first access or while still waiting; the exit cycle lets the pipe move
  always_comb begin
    w_freeze = ((r_state == RUN) & i_mmem & ~i_dmem_ready) | (w_in_wait & ~w_wait_exit);
  end

  // Load in EX feeding an operand the ID instruction actually reads
  always_comb begin
    w_load_use = ~w_freeze & i_em2reg &
                 ((i_users & reg_hit(i_ewreg, i_ern, i_rs)) |
                  (i_usert & reg_hit(i_ewreg, i_ern, i_rt)));
  end

  // Register enables and bubbles; reset holds everything still with bubbles into WB
  always_comb begin
    w_wpcir     = resetn & ~w_freeze & ~w_load_use;
    o_wpcir     = w_wpcir;
    o_de_en     = resetn & ~w_freeze;
    o_em_en     = resetn & ~w_freeze;
    o_de_bubble = w_load_use;
    o_mw_bubble = ~resetn | w_freeze;
    o_fd_flush  = (DELAY_SLOT == 0) & i_branch_taken & w_wpcir;
    o_dmem_req  = resetn & i_mmem;
  end

  // A timeout is an abort only if the memory did not complete in that same cycle
  always_comb begin
    o_mem_err = w_timeout & ~i_dmem_ready;
  end

  // Memory handshake FSM; the wait counter restarts on every entry to MWAIT
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (i_mmem & ~i_dmem_ready) begin
            r_state    <= MWAIT;
            r_wait_cnt <= '0;
          end
        end
        MWAIT: begin
          r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          if (w_wait_exit) begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state    <= RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the front end did not advance
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else if (~w_wpcir && ~(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cycles = r_stall_cnt;

  pipe_fwd_unit u_fwd_a (
    .i_src   (i_rs),
    .i_ewreg (i_ewreg),
    .i_em2reg(i_em2reg),
    .i_ern   (i_ern),
    .i_mwreg (i_mwreg),
    .i_mm2reg(i_mm2reg),
    .i_mrn   (i_mrn),
    .o_sel   (o_fwda)
  );

  pipe_fwd_unit u_fwd_b (
    .i_src   (i_rt),
    .i_ewreg (i_ewreg),
    .i_em2reg(i_em2reg),
    .i_ern   (i_ern),
    .i_mwreg (i_mwreg),
    .i_mm2reg(i_mm2reg),
    .i_mrn   (i_mrn),
    .o_sel   (o_fwdb)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose: directed checks of forwarding, load-use, memory wait/timeout, flush and reset.
// Latency: inputs change 1 ns after a rising edge, outputs are sampled 1 ns later.
// Backpressure: dmem_ready is driven directly by the stimulus.
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       resetn;
  logic [4:0] i_rs, i_rt, i_ern, i_mrn;
  logic       i_users, i_usert, i_branch_taken;
  logic       i_ewreg, i_em2reg, i_mwreg, i_mm2reg, i_mmem, i_dmem_ready;

  logic        dmem_req, wpcir, fd_flush, de_en, de_bubble, em_en, mw_bubble, mem_err;
  logic [1:0]  fwda, fwdb;
  logic [31:0] stall_cycles;

  logic        s_dmem_req, s_wpcir, s_fd_flush, s_de_en, s_de_bubble, s_em_en, s_mw_bubble, s_mem_err;
  logic [1:0]  s_fwda, s_fwdb;
  logic [2:0]  s_stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  // Main instance: flushing branches, short timeout, full-width counter
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32), .DELAY_SLOT(0)) u_dut (
    .clock(clock), .resetn(resetn),
    .i_rs(i_rs), .i_rt(i_rt), .i_users(i_users), .i_usert(i_usert),
    .i_branch_taken(i_branch_taken),
    .i_ewreg(i_ewreg), .i_em2reg(i_em2reg), .i_ern(i_ern),
    .i_mwreg(i_mwreg), .i_mm2reg(i_mm2reg), .i_mrn(i_mrn),
    .i_mmem(i_mmem), .i_dmem_ready(i_dmem_ready),
    .o_dmem_req(dmem_req), .o_wpcir(wpcir), .o_fd_flush(fd_flush),
    .o_de_en(de_en), .o_de_bubble(de_bubble), .o_em_en(em_en),
    .o_mw_bubble(mw_bubble), .o_fwda(fwda), .o_fwdb(fwdb),
    .o_mem_err(mem_err), .o_stall_cycles(stall_cycles)
  );

  // Second instance: delay-slot branches and a 3-bit counter that saturates early
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3), .DELAY_SLOT(1)) u_sat (
    .clock(clock), .resetn(resetn),
    .i_rs(i_rs), .i_rt(i_rt), .i_users(i_users), .i_usert(i_usert),
    .i_branch_taken(i_branch_taken),
    .i_ewreg(i_ewreg), .i_em2reg(i_em2reg), .i_ern(i_ern),
    .i_mwreg(i_mwreg), .i_mm2reg(i_mm2reg), .i_mrn(i_mrn),
    .i_mmem(i_mmem), .i_dmem_ready(i_dmem_ready),
    .o_dmem_req(s_dmem_req), .o_wpcir(s_wpcir), .o_fd_flush(s_fd_flush),
    .o_de_en(s_de_en), .o_de_bubble(s_de_bubble), .o_em_en(s_em_en),
    .o_mw_bubble(s_mw_bubble), .o_fwda(s_fwda), .o_fwdb(s_fwdb),
    .o_mem_err(s_mem_err), .o_stall_cycles(s_stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    i_rs = '0; i_rt = '0; i_ern = '0; i_mrn = '0;
    i_users = 1'b0; i_usert = 1'b0; i_branch_taken = 1'b0;
    i_ewreg = 1'b0; i_em2reg = 1'b0; i_mwreg = 1'b0; i_mm2reg = 1'b0;
    i_mmem = 1'b0; i_dmem_ready = 1'b0;
  endtask

  initial begin
    // Reset: everything held, memory request and flush masked
    resetn = 1'b0;
    idle();
    i_mmem = 1'b1;
    i_branch_taken = 1'b1;
    #3;
    check("rst_wpcir",     32'(wpcir),     32'd0);
    check("rst_de_en",     32'(de_en),     32'd0);
    check("rst_em_en",     32'(em_en),     32'd0);
    check("rst_dmem_req",  32'(dmem_req),  32'd0);
    check("rst_fd_flush",  32'(fd_flush),  32'd0);
    check("rst_mw_bubble", 32'(mw_bubble), 32'd1);
    check("rst_mem_err",   32'(mem_err),   32'd0);
    check("rst_stall",     stall_cycles,   32'd0);
    #9;
    resetn = 1'b1;
    idle();
    tick();
    check("run_wpcir", 32'(wpcir), 32'd1);
    check("run_stall", stall_cycles, 32'd0);

    // 1: ALU hazard forwarding and priority
    i_ern = 5'd5; i_ewreg = 1'b1; i_rs = 5'd5; i_users = 1'b1;
    i_mwreg = 1'b1; i_mrn = 5'd5;
    #1;
    check("alu_fwda_ex",   32'(fwda),      32'd1);
    check("alu_fwdb_rf",   32'(fwdb),      32'd0);
    check("alu_wpcir",     32'(wpcir),     32'd1);
    check("alu_de_bubble", 32'(de_bubble), 32'd0);
    i_ewreg = 1'b0;
    #1;
    check("alu_fwda_malu", 32'(fwda), 32'd2);
    i_mm2reg = 1'b1;
    #1;
    check("alu_fwda_mmem", 32'(fwda), 32'd3);
    i_rt = 5'd5;
    #1;
    check("alu_fwdb_mmem", 32'(fwdb), 32'd3);
    tick();
    check("alu_stall", stall_cycles, 32'd0);

    // 2: load-use stall, then load data forwarded from MEM
    idle();
    i_ewreg = 1'b1; i_em2reg = 1'b1; i_ern = 5'd7; i_rt = 5'd7; i_usert = 1'b1;
    #1;
    check("lu_wpcir",     32'(wpcir),     32'd0);
    check("lu_de_bubble", 32'(de_bubble), 32'd1);
    check("lu_de_en",     32'(de_en),     32'd1);
    check("lu_em_en",     32'(em_en),     32'd1);
    check("lu_mw_bubble", 32'(mw_bubble), 32'd0);
    check("lu_fwdb",      32'(fwdb),      32'd0);
    tick();
    check("lu_stall", stall_cycles, 32'd1);
    idle();
    i_mwreg = 1'b1; i_mm2reg = 1'b1; i_mrn = 5'd7; i_rt = 5'd7; i_usert = 1'b1;
    #1;
    check("lu_fwdb_mmem", 32'(fwdb),  32'd3);
    check("lu_after",     32'(wpcir), 32'd1);
    i_ewreg = 1'b1; i_em2reg = 1'b1; i_ern = 5'd7; i_usert = 1'b0;
    #1;
    check("lu_unused_rt", 32'(wpcir), 32'd1);
    tick();

    // Zero-latency memory access does not stall
    idle();
    i_mmem = 1'b1; i_dmem_ready = 1'b1;
    #1;
    check("zl_wpcir",     32'(wpcir),     32'd1);
    check("zl_dmem_req",  32'(dmem_req),  32'd1);
    check("zl_mw_bubble", 32'(mw_bubble), 32'd0);
    tick();
    check("zl_stall", stall_cycles, 32'd1);

    // 3: memory wait of three cycles
    idle();
    i_mmem = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("mw_frz_wpcir",  32'(wpcir),     32'd0);
      check("mw_frz_bubble", 32'(mw_bubble), 32'd1);
      check("mw_frz_req",    32'(dmem_req),  32'd1);
      check("mw_frz_de_en",  32'(de_en),     32'd0);
      tick();
    end
    i_dmem_ready = 1'b1;
    #1;
    check("mw_exit_wpcir",  32'(wpcir),     32'd1);
    check("mw_exit_em_en",  32'(em_en),     32'd1);
    check("mw_exit_bubble", 32'(mw_bubble), 32'd0);
    check("mw_exit_req",    32'(dmem_req),  32'd1);
    check("mw_exit_err",    32'(mem_err),   32'd0);
    tick();
    idle();
    #1;
    check("mw_stall",     stall_cycles,          32'd4);
    check("mw_sat_stall", 32'(s_stall_cycles),   32'd4);
    check("mw_run",       32'(wpcir),            32'd1);

    // 4: timeout after four MWAIT cycles
    i_mmem = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("to_mem_err", 32'(mem_err), (c == 4) ? 32'd1 : 32'd0);
      check("to_wpcir",   32'(wpcir),   (c == 4) ? 32'd1 : 32'd0);
      tick();
    end
    idle();
    #1;
    check("to_err_clr",    32'(mem_err),        32'd0);
    check("to_run",        32'(wpcir),          32'd1);
    check("to_stall",      stall_cycles,        32'd8);
    check("to_sat_stall",  32'(s_stall_cycles), 32'd7);

    // 5: taken branch flushes only without a delay slot, and never while stalled
    i_branch_taken = 1'b1;
    #1;
    check("br_flush",     32'(fd_flush),   32'd1);
    check("br_ds_flush",  32'(s_fd_flush), 32'd0);
    i_ewreg = 1'b1; i_em2reg = 1'b1; i_ern = 5'd3; i_rs = 5'd3; i_users = 1'b1;
    #1;
    check("br_lu_flush", 32'(fd_flush), 32'd0);
    check("br_lu_wpcir", 32'(wpcir),    32'd0);
    tick();
    check("br_stall", stall_cycles, 32'd9);

    // 6: reset in the middle of a memory wait
    idle();
    i_mmem = 1'b1;
    tick();
    tick();
    #1;
    resetn = 1'b0;
    #1;
    check("mr_dmem_req", 32'(dmem_req), 32'd0);
    check("mr_mem_err",  32'(mem_err),  32'd0);
    check("mr_stall",    stall_cycles,  32'd0);
    check("mr_wpcir",    32'(wpcir),    32'd0);
    #2;
    resetn = 1'b1;
    i_mmem = 1'b0;
    #1;
    check("mr_run_wpcir",  32'(wpcir),     32'd1);
    check("mr_run_bubble", 32'(mw_bubble), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("mr_no_err", 32'(mem_err), 32'd0);
    end
    check("mr_stall_after", stall_cycles, 32'd0);
    i_ewreg = 1'b1; i_ern = 5'd0; i_users = 1'b1; i_usert = 1'b1;
    i_mwreg = 1'b1; i_mrn = 5'd0;
    #1;
    check("r0_fwda", 32'(fwda), 32'd0);
    check("r0_fwdb", 32'(fwdb), 32'd0);
    i_em2reg = 1'b1;
    #1;
    check("r0_no_lu", 32'(wpcir), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
